// File: rtl/pcie_tag_pool.sv
// pcie_tag_pool: free-tag allocator for the PCIe request path.
// Offers the lowest free tag each cycle and reclaims returned tags.
module pcie_tag_pool #(
    parameter int B_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    output logic               alloc_valid,
    input  logic               alloc_ready,
    output logic [B_WIDTH-1:0] alloc_tag,
    input  logic               rel_valid,
    output logic               rel_ready,
    input  logic [B_WIDTH-1:0] rel_tag,
    output logic [B_WIDTH:0]   free_count,
    output logic               empty,
    output logic               err_double_free
);

    localparam int N = 2 ** B_WIDTH;
    localparam logic [B_WIDTH:0] FULL = (B_WIDTH + 1)'(N);

    logic [N-1:0]       free_mask;
    logic [N-1:0]       mask_next;
    logic [B_WIDTH:0]   count_next;
    logic [B_WIDTH-1:0] lz_tag;
    logic               lz_found;
    logic [B_WIDTH-1:0] lz_bit;
    logic [B_WIDTH-1:0] rel_bit;
    logic               handoff;
    logic               load;
    logic               rel_hit;
    logic               rel_bad;
    logic               rel_ok;

    // Leading-zero count: the highest set bit is the lowest free tag.
    always_comb begin
        lz_tag = '0;
        for (int i = 0; i < N; i++) begin
            if (free_mask[i]) begin
                lz_tag = ~B_WIDTH'(i);
            end
        end
    end

    // Tag t lives at bit N-1-t, which is simply the bitwise inverse of t.
    assign lz_found = |free_mask;
    assign lz_bit   = ~lz_tag;
    assign rel_bit  = ~rel_tag;

    assign handoff = alloc_valid & alloc_ready;
    assign load    = (~alloc_valid | alloc_ready) & lz_found;

    // A return is illegal if the tag is already free or is the staged one.
    assign rel_hit = free_mask[rel_bit]
                   | (alloc_valid & (rel_tag == alloc_tag));
    assign rel_bad = rel_valid & rel_hit;
    assign rel_ok  = rel_valid & ~rel_hit;

    assign rel_ready = ~rst;
    assign empty     = (free_count == '0);

    // Next free mask: load clears its bit, a legal return sets a different one.
    always_comb begin
        mask_next = free_mask;
        if (load) begin
            mask_next[lz_bit] = 1'b0;
        end
        if (rel_ok) begin
            mask_next[rel_bit] = 1'b1;
        end
    end

    // Count of tags not held by consumers; staging a tag does not change it.
    always_comb begin
        count_next = free_count;
        if (rel_ok && !handoff) begin
            count_next = free_count + 1'b1;
        end else if (!rel_ok && handoff) begin
            count_next = free_count - 1'b1;
        end
    end

    // State registers: mask, output stage, count and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_mask       <= '1;
            alloc_valid     <= 1'b0;
            alloc_tag       <= '0;
            free_count      <= FULL;
            err_double_free <= 1'b0;
        end else begin
            free_mask       <= mask_next;
            free_count      <= count_next;
            err_double_free <= rel_bad;
            if (load) begin
                alloc_valid <= 1'b1;
                alloc_tag   <= lz_tag;
            end else if (handoff) begin
                alloc_valid <= 1'b0;
            end
        end
    end

endmodule
